rs_syndrome_stream: RTL

//  Sequential, parametrised Reed-Solomon syndrome calculator over GF(2^SYMBOL_WIDTH).
//  - Accepts one received symbol per cycle under a valid/ready handshake.
//  - Accumulates NSYN syndromes by Horner's rule.
//  - Presents the complete syndrome vector plus a nonzero flag under an output handshake.
//  - Sits at the front of the RS decoder and feeds the key-equation solver; replaces the

---
 rtl/rs_syndrome_stream.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/rs_syndrome_stream.sv
`default_nettype none
// ============================================================================
// Module      : rs_syndrome_stream
// Description : Streaming Reed-Solomon syndrome calculator over GF(2^m).
//               Takes one received symbol per cycle (highest degree first),
//               accumulates NSYN syndromes by Horner's rule and presents the
//               syndrome vector plus a nonzero flag under a valid/ready
//               handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module rs_syndrome_stream #(
  parameter int unsigned           SYMBOL_WIDTH = 4,
  parameter int unsigned           N            = 10,
  parameter int unsigned           NSYN         = 2,
  parameter logic [SYMBOL_WIDTH:0] PRIM_POLY    = 5'h13,
  parameter int unsigned           FCR          = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [SYMBOL_WIDTH-1:0]        in_data,
  input  logic                           in_sop,
  output logic                           syn_valid,
  input  logic                           syn_ready,
  output logic [NSYN*SYMBOL_WIDTH-1:0]   syn_data,
  output logic                           syn_nonzero,
  output logic                           frame_err
);

  localparam int unsigned     CNT_W    = $clog2(N + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam int unsigned     VEC_W    = NSYN * SYMBOL_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Multiply by alpha (x) and reduce modulo the field polynomial.
  function automatic logic [SYMBOL_WIDTH-1:0] gf_xtime(input logic [SYMBOL_WIDTH-1:0] v);
    return {v[SYMBOL_WIDTH-2:0], 1'b0} ^
           (v[SYMBOL_WIDTH-1] ? PRIM_POLY[SYMBOL_WIDTH-1:0] : '0);
  endfunction

  // Shift-and-add GF multiply; with a constant operand it collapses to an XOR network.
  function automatic logic [SYMBOL_WIDTH-1:0] gf_mul(input logic [SYMBOL_WIDTH-1:0] a,
                                                     input logic [SYMBOL_WIDTH-1:0] b);
    logic [SYMBOL_WIDTH-1:0] acc;
    logic [SYMBOL_WIDTH-1:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < int'(SYMBOL_WIDTH); i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = gf_xtime(sh);
    end
    return acc;
  endfunction

  // alpha^k, evaluated at elaboration only.
  function automatic logic [SYMBOL_WIDTH-1:0] alpha_pow(input int unsigned k);
    logic [SYMBOL_WIDTH-1:0] v;
    v = SYMBOL_WIDTH'(1);
    for (int unsigned i = 0; i < k; i++) v = gf_xtime(v);
    return v;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [VEC_W-1:0] syn_q, syn_d;
  logic             frame_err_q, frame_err_d;

  logic [VEC_W-1:0] syn_step;
  logic             accept;
  logic             start;

  // One Horner step per syndrome: S_j * alpha^(FCR+j) + r.
  for (genvar j = 0; j < int'(NSYN); j++) begin : g_syn
    localparam logic [SYMBOL_WIDTH-1:0] ROOT = alpha_pow(FCR + j);
    assign syn_step[j*SYMBOL_WIDTH +: SYMBOL_WIDTH] =
      gf_mul(syn_q[j*SYMBOL_WIDTH +: SYMBOL_WIDTH], ROOT) ^ in_data;
  end

  assign in_ready    = (state_q == ST_DONE) ? syn_ready : 1'b1;
  assign syn_valid   = (state_q == ST_DONE);
  assign syn_data    = syn_q;
  assign syn_nonzero = |syn_q;
  assign frame_err   = frame_err_q;
  assign accept      = in_valid & in_ready;

  // Next-state logic: a start-of-codeword symbol seeds every accumulator with the symbol.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    syn_d       = syn_q;
    frame_err_d = frame_err_q;
    start       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept && in_sop) start = 1'b1;
      end
      ST_ACCUM: begin
        if (accept) begin
          if (in_sop) begin
            frame_err_d = 1'b1;
            start       = 1'b1;
          end else begin
            syn_d = syn_step;
            if (cnt_q == CNT_LAST) begin
              state_d = ST_DONE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
      end
      ST_DONE: begin
        if (syn_ready) begin
          if (in_valid && in_sop) begin
            start = 1'b1;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (start) begin
      syn_d   = {NSYN{in_data}};
      cnt_d   = (N == 1) ? '0 : CNT_ONE;
      state_d = (N == 1) ? ST_DONE : ST_ACCUM;
    end
  end

  // State, counter, accumulator and sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      syn_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      syn_q       <= syn_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule
`default_nettype wire
